// File: rtl/otter_intr_pkg.sv
// otter_intr_pkg: shared types and defaults for the OTTER interrupt controller.
//   intr_state_t    : controller FSM state (IDLE, ASSERT, SVC_LO, SVC_HI)
//   NUM_SRC_DEF     : default number of interrupt sources
//   SYNC_STAGES_DEF : default synchronizer depth
//   causeW()        : width of cause_id for a given source count (minimum 1)
package otter_intr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    SVC_LO = 2'd2,
    SVC_HI = 2'd3
  } intr_state_t;

  localparam int NUM_SRC_DEF     = 8;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic int causeW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/otter_intr_if.sv
// otter_intr_if: bus between the interrupt controller and its environment
// (peripherals, CSR file, control unit).
//   slave  : controller side (inputs irq_src/mie/mask_we/mask_wdata/int_taken,
//            outputs interrupt/cause_id/pending/en_mask)
//   master : environment side, directions mirrored
interface otter_intr_if
  import otter_intr_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
);
  localparam int CW = causeW(NUM_SRC);

  logic [NUM_SRC-1:0] irq_src;
  logic               mie;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               int_taken;
  logic               interrupt;
  logic [CW-1:0]      cause_id;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] en_mask;

  modport slave (
    input  irq_src, mie, mask_we, mask_wdata, int_taken,
    output interrupt, cause_id, pending, en_mask
  );

  modport master (
    output irq_src, mie, mask_we, mask_wdata, int_taken,
    input  interrupt, cause_id, pending, en_mask
  );
endinterface

// File: rtl/otter_intr_sync_edge.sv
// otter_intr_sync_edge: one interrupt source's synchronizer chain plus event
// detector.
//   clk, RST : clock, asynchronous active-high reset
//   src      : raw asynchronous request
//   evt      : with OTTER_INTR_EDGE_EN defined, a one-cycle pulse on a
//              synchronized rising edge; otherwise the synchronized level
module otter_intr_sync_edge
  import otter_intr_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic RST,
  input  logic src,
  output logic evt
);

  logic [SYNC_STAGES-1:0] syncQ;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) syncQ <= '0;
    else     syncQ <= {syncQ[SYNC_STAGES-2:0], src};
  end

`ifdef OTTER_INTR_EDGE_EN
  logic syncPrev;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) syncPrev <= 1'b0;
    else     syncPrev <= syncQ[SYNC_STAGES-1];
  end

  assign evt = syncQ[SYNC_STAGES-1] & ~syncPrev;
`else
  assign evt = syncQ[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: interrupt controller for the OTTER multicycle CU.
// Synchronizes NUM_SRC requests, keeps them pending, picks the lowest-index
// enabled one and holds `interrupt` until INT_TAKEN; then blacks out further
// requests until MIE has gone low (trap entry) and high again (mret).
//   clk, RST : clock, asynchronous active-high reset
//   bus      : otter_intr_if.slave (irq_src, mie, mask_we, mask_wdata,
//              int_taken in; interrupt, cause_id, pending, en_mask out)
// Build option OTTER_INTR_EDGE_EN: edge-triggered pending bits cleared by
// acknowledge; when undefined, pending mirrors the synchronized levels.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int NUM_SRC     = NUM_SRC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic         clk,
  input logic         RST,
  otter_intr_if.slave bus
);

  localparam int CW = causeW(NUM_SRC);

  intr_state_t        state, stateNxt;
  logic [CW-1:0]      causeQ, causeNxt, winner;
  logic [NUM_SRC-1:0] srcEvt, pendingQ, enMaskQ, eligible;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    otter_intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
      .clk (clk),
      .RST (RST),
      .src (bus.irq_src[i]),
      .evt (srcEvt[i])
    );
  end

`ifdef OTTER_INTR_EDGE_EN
  logic [NUM_SRC-1:0] ackClr;

  always_comb begin
    ackClr = '0;
    if (state == ASSERT && bus.int_taken) ackClr[causeQ] = 1'b1;
  end

  // OR-ing the new edge in after the clear makes a colliding edge win.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) pendingQ <= '0;
    else     pendingQ <= (pendingQ & ~ackClr) | srcEvt;
  end
`else
  always_ff @(posedge clk or posedge RST) begin
    if (RST) pendingQ <= '0;
    else     pendingQ <= srcEvt;
  end
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST)              enMaskQ <= '1;
    else if (bus.mask_we) enMaskQ <= bus.mask_wdata;
  end

  assign eligible = pendingQ & enMaskQ;

  // Scan high to low so the lowest set index is written last and wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eligible[i]) winner = CW'(i);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      causeQ <= '0;
    end else begin
      state  <= stateNxt;
      causeQ <= causeNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    causeNxt = causeQ;
    case (state)
      IDLE:
        if (bus.mie && |eligible) begin
          stateNxt = ASSERT;
          causeNxt = winner;
        end
      ASSERT:
        if (bus.int_taken)                         stateNxt = SVC_LO;
        else if (!bus.mie || !enMaskQ[causeQ])     stateNxt = IDLE;
      SVC_LO: if (!bus.mie) stateNxt = SVC_HI;
      SVC_HI: if (bus.mie)  stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Decoded from the state register only, so reset drops it asynchronously
  // and no input reaches it combinationally.
  assign bus.interrupt = (state == ASSERT);
  assign bus.cause_id  = causeQ;
  assign bus.pending   = pendingQ;
  assign bus.en_mask   = enMaskQ;

endmodule
